// File: rtl/sha256_round_ctrl.sv
`timescale 1ns/1ps

// Ch(e,f,g) term of the SHA-256 round: bits of f where e is 1, bits of g where e is 0.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no handshake.
module func_ch (
  input  logic [31:0] e,
  input  logic [31:0] f,
  input  logic [31:0] g,
  output logic [31:0] ch
);

  assign ch = (e & f) ^ (~e & g);

endmodule

// SHA-256 compression controller: loads 16 message words, runs 64 rounds, adds the result into the chaining hash.
// Latency: done pulses 66 cycles after the 16th word handshake (64 rounds, one final add, then the done cycle).
// Backpressure: word_ready is low during rounds, finalisation and whenever init is high; words offered then are dropped.
module sha256_round_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         init,
  input  logic         word_valid,
  input  logic [31:0]  word_in,
  output logic         word_ready,
  output logic         busy,
  output logic         done,
  output logic [255:0] digest
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ROUND = 2'd2,
    ST_FINAL = 2'd3
  } state_t;

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Rotations written as fixed bit slices so each sigma is pure wiring plus XOR.
  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  state_t      state;
  logic [3:0]  count;
  logic [5:0]  round;
  logic        done_q;

  // Chaining hash H0..H7 and working registers A..H.
  logic [31:0] h_reg [8];
  logic [31:0] reg_a, reg_b, reg_c, reg_d, reg_e, reg_f, reg_g, reg_h;

  // Message-schedule window: w_win[0] is always W[round].
  logic [31:0] w_win [16];

  logic        hs;
  logic        last_word;
  logic        in_round;
  logic        in_final;
  logic [31:0] ch_val;
  logic [31:0] maj_val;
  logic [31:0] t1;
  logic [31:0] t2;
  logic [31:0] w_new;

  func_ch u_func_ch (
    .e  (reg_e),
    .f  (reg_f),
    .g  (reg_g),
    .ch (ch_val)
  );

  // init always wins over a word in the same cycle, so it masks ready in every state.
  assign word_ready = ((state == ST_IDLE) || (state == ST_LOAD)) && !init;
  assign busy       = (state == ST_ROUND) || (state == ST_FINAL);
  assign done       = done_q;
  assign digest     = {h_reg[0], h_reg[1], h_reg[2], h_reg[3],
                       h_reg[4], h_reg[5], h_reg[6], h_reg[7]};

  assign hs        = word_valid && word_ready;
  assign last_word = hs && (state == ST_LOAD) && (count == 4'd15);
  assign in_round  = (state == ST_ROUND) && !init;
  assign in_final  = (state == ST_FINAL) && !init;

  assign maj_val = (reg_a & reg_b) ^ (reg_a & reg_c) ^ (reg_b & reg_c);
  assign t1      = reg_h + big_sigma1(reg_e) + ch_val + K_ROM[round] + w_win[0];
  assign t2      = big_sigma0(reg_a) + maj_val;
  // With w_win[k] = W[t+k], this is W[t+16] built from W[t+14], W[t+9], W[t+1], W[t].
  assign w_new   = small_sigma1(w_win[14]) + w_win[9] + small_sigma0(w_win[1]) + w_win[0];

  // Control FSM: word counting, round sequencing, abort on init and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      count  <= 4'd0;
      round  <= 6'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (init) begin
        state <= ST_IDLE;
        count <= 4'd0;
        round <= 6'd0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (hs) begin
              count <= 4'd1;
              state <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            if (last_word) begin
              count <= 4'd0;
              round <= 6'd0;
              state <= ST_ROUND;
            end else if (hs) begin
              count <= count + 4'd1;
            end
          end
          ST_ROUND: begin
            round <= round + 6'd1;
            if (round == 6'd63) begin
              state <= ST_FINAL;
            end
          end
          ST_FINAL: begin
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Chaining hash: IV on reset or init, accumulate the working registers in the final cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) h_reg[i] <= IV[i];
    end else if (init) begin
      for (int i = 0; i < 8; i++) h_reg[i] <= IV[i];
    end else if (in_final) begin
      h_reg[0] <= h_reg[0] + reg_a;
      h_reg[1] <= h_reg[1] + reg_b;
      h_reg[2] <= h_reg[2] + reg_c;
      h_reg[3] <= h_reg[3] + reg_d;
      h_reg[4] <= h_reg[4] + reg_e;
      h_reg[5] <= h_reg[5] + reg_f;
      h_reg[6] <= h_reg[6] + reg_g;
      h_reg[7] <= h_reg[7] + reg_h;
    end
  end

  // Working registers: seeded from the chaining hash on the last word, then one round per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_a <= '0; reg_b <= '0; reg_c <= '0; reg_d <= '0;
      reg_e <= '0; reg_f <= '0; reg_g <= '0; reg_h <= '0;
    end else if (last_word) begin
      reg_a <= h_reg[0]; reg_b <= h_reg[1]; reg_c <= h_reg[2]; reg_d <= h_reg[3];
      reg_e <= h_reg[4]; reg_f <= h_reg[5]; reg_g <= h_reg[6]; reg_h <= h_reg[7];
    end else if (in_round) begin
      reg_h <= reg_g;
      reg_g <= reg_f;
      reg_f <= reg_e;
      reg_e <= reg_d + t1;
      reg_d <= reg_c;
      reg_c <= reg_b;
      reg_b <= reg_a;
      reg_a <= t1 + t2;
    end
  end

  // Schedule window: shifts in host words while loading and expanded words while rounding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) w_win[i] <= '0;
    end else if (hs || in_round) begin
      for (int i = 0; i < 15; i++) w_win[i] <= w_win[i+1];
      w_win[15] <= hs ? word_in : w_new;
    end
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
`timescale 1ns/1ps

module tb_sha256_round_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         init = 1'b0;
  logic         word_valid = 1'b0;
  logic [31:0]  word_in = '0;
  logic         word_ready;
  logic         busy;
  logic         done;
  logic [255:0] digest;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [255:0] IV_VEC    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_VEC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_VEC = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_VEC   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic [31:0] kt [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Reference chaining hash and the block currently being sent.
  logic [31:0] mh [8];
  logic [31:0] blk [16];

  sha256_round_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init       (init),
    .word_valid (word_valid),
    .word_in    (word_in),
    .word_ready (word_ready),
    .busy       (busy),
    .done       (done),
    .digest     (digest)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] model_digest();
    return {mh[0], mh[1], mh[2], mh[3], mh[4], mh[5], mh[6], mh[7]};
  endfunction

  task automatic model_iv();
    logic [255:0] iv;
    iv = IV_VEC;
    for (int i = 0; i < 8; i++) mh[i] = iv[255-32*i -: 32];
  endtask

  // Textbook SHA-256 compression of blk into mh, with a full 64-word schedule.
  task automatic model_compress();
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] s0, s1, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = blk[t];
    for (int t = 16; t < 64; t++) begin
      s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int i = 0; i < 8; i++) v[i] = mh[i];
    for (int t = 0; t < 64; t++) begin
      s1 = rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25);
      t1 = v[7] + s1 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kt[t] + w[t];
      s0 = rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22);
      t2 = s0 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) mh[i] = mh[i] + v[i];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init();
    init = 1'b1;
    word_valid = 1'b0;
    tick();
    init = 1'b0;
    model_iv();
  endtask

  // Offers blk word by word; returns one cycle after the 16th handshake edge (round 0).
  task automatic send_words(input bit gaps);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < 16 && guard < 400) begin
      guard++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        word_valid = 1'b0;
        word_in = $urandom;
      end else begin
        word_valid = 1'b1;
        word_in = blk[i];
      end
      #1;
      if (word_valid && word_ready) i++;
      tick();
    end
    word_valid = 1'b0;
    check("load_handshakes", i, 16);
  endtask

  // Waits for done, checking latency and that ROUND/FINAL keep ready low, busy high and digest stable.
  task automatic wait_done(input bit junk, input string tag);
    int k;
    int bad;
    bit got;
    logic [255:0] prev;
    k = 1;
    bad = 0;
    got = 1'b0;
    prev = digest;
    while (k <= 120) begin
      if (junk && k <= 65) begin
        word_valid = 1'($urandom_range(0, 1));
        word_in = $urandom;
      end else begin
        word_valid = 1'b0;
      end
      #1;
      if (done) begin
        word_valid = 1'b0;
        got = 1'b1;
        break;
      end
      if (k <= 65 && (word_ready !== 1'b0 || busy !== 1'b1 || digest !== prev)) bad++;
      tick();
      k++;
    end
    word_valid = 1'b0;
    check({tag, "_done_seen"}, got, 1);
    check({tag, "_done_latency"}, k, 66);
    check({tag, "_round_outputs"}, bad, 0);
    check({tag, "_busy_at_done"}, busy, 0);
    model_compress();
    check({tag, "_digest_model"}, digest, model_digest());
  endtask

  task automatic fill_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0] = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  initial begin
    int cnt;
    model_iv();

    // Reset state, asserted from time zero.
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", word_ready, 1);
    check("rst_digest", digest, IV_VEC);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // "abc"
    do_init();
    check("init_digest", digest, IV_VEC);
    fill_abc();
    send_words(1'b0);
    wait_done(1'b0, "abc");
    check("abc_vector", digest, ABC_VEC);
    tick();
    check("done_one_cycle", done, 0);

    // Empty message
    do_init();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0] = 32'h80000000;
    send_words(1'b0);
    wait_done(1'b0, "empty");
    check("empty_vector", digest, EMPTY_VEC);

    // Two-block message, second block starting in the done cycle
    do_init();
    blk = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
            32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
            32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
            32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    send_words(1'b0);
    wait_done(1'b0, "two_b1");
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[15] = 32'h000001c0;
    send_words(1'b0);
    wait_done(1'b0, "two_b2");
    check("two_vector", digest, TWO_VEC);

    // init collides with a valid word in IDLE: init wins, word refused
    init = 1'b1;
    word_valid = 1'b1;
    word_in = 32'hdeadbeef;
    #1;
    check("init_masks_ready", word_ready, 0);
    tick();
    init = 1'b0;
    word_valid = 1'b0;
    model_iv();
    check("init_collide_digest", digest, IV_VEC);

    // Stalls in LOAD, junk during ROUND
    fill_abc();
    send_words(1'b1);
    wait_done(1'b1, "stall");
    check("stall_vector", digest, ABC_VEC);

    // Abort at round 30
    do_init();
    fill_abc();
    send_words(1'b0);
    for (int j = 0; j < 30; j++) tick();
    init = 1'b1;
    #1;
    check("abort_ready", word_ready, 0);
    tick();
    init = 1'b0;
    model_iv();
    check("abort_busy", busy, 0);
    check("abort_digest", digest, IV_VEC);
    cnt = 0;
    for (int j = 0; j < 80; j++) begin
      if (done) cnt++;
      tick();
    end
    check("abort_no_done", cnt, 0);
    send_words(1'b0);
    wait_done(1'b0, "post_abort");
    check("post_abort_vector", digest, ABC_VEC);

    // Reset at round 40
    tick();
    fill_abc();
    send_words(1'b0);
    for (int j = 0; j < 40; j++) tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_digest", digest, IV_VEC);
    check("midrst_ready", word_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    model_iv();
    tick();

    // Random blocks, chained without init
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 16; i++) blk[i] = $urandom;
      send_words(1'($urandom_range(0, 1)));
      wait_done(1'($urandom_range(0, 1)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
